// File: rtl/pe_chain_ctrl.sv
// pe_chain_ctrl
// Sequences one chain of ARRAY_SIZE signed MAC PEs. For each of num_tiles
// tiles it reads k_len operand beats from the input/weight buffers, tracks
// live data down the chain, waits for the chain to drain, then presents the
// tile result downstream with a valid/ready handshake.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   start                    begin a job (sampled only when idle)
//   k_len, num_tiles         beats per tile / tiles per job (latched at start)
//   inp_base, wgt_base       operand buffer base addresses (latched at start)
//   inp_rd_en, inp_rd_addr   input buffer read strobe / address
//   wgt_rd_en, wgt_rd_addr   weight buffer read strobe / address
//   acc_clr                  zero the first PE's acc_in (first beat of a tile)
//   stage_vld                bit j set while PE j holds live data
//   out_valid, out_ready     tile result handshake
//   out_tile                 index of the tile being presented
//   busy, done               job in progress / one-cycle completion pulse
module pe_chain_ctrl #(
    parameter int ARRAY_SIZE = 4,
    parameter int ADDR_WIDTH = 8,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [CNT_WIDTH-1:0]  k_len,
    input  logic [CNT_WIDTH-1:0]  num_tiles,
    input  logic [ADDR_WIDTH-1:0] inp_base,
    input  logic [ADDR_WIDTH-1:0] wgt_base,
    output logic                  inp_rd_en,
    output logic [ADDR_WIDTH-1:0] inp_rd_addr,
    output logic                  wgt_rd_en,
    output logic [ADDR_WIDTH-1:0] wgt_rd_addr,
    output logic                  acc_clr,
    output logic [ARRAY_SIZE-1:0] stage_vld,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [CNT_WIDTH-1:0]  out_tile,
    output logic                  busy,
    output logic                  done
);

    localparam int DW = $clog2(ARRAY_SIZE + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_DRAIN,
        S_OUT,
        S_FIN
    } state_t;

    state_t state, state_nx;

    logic [CNT_WIDTH-1:0]  k_len_q;
    logic [CNT_WIDTH-1:0]  num_tiles_q;
    logic [CNT_WIDTH-1:0]  beat;
    logic [CNT_WIDTH-1:0]  tile;
    logic [ADDR_WIDTH-1:0] inp_ptr;
    logic [ADDR_WIDTH-1:0] wgt_ptr;
    logic [ADDR_WIDTH-1:0] wgt_base_q;
    logic [DW-1:0]         drain_cnt;
    logic                  skip;

    logic last_beat;
    logic last_tile;
    logic zero_cfg;

    assign last_beat = (beat == k_len_q - CNT_WIDTH'(1));
    assign last_tile = (tile == num_tiles_q - CNT_WIDTH'(1));
    assign zero_cfg  = (k_len == '0) || (num_tiles == '0);

    assign wgt_rd_en   = inp_rd_en;
    assign inp_rd_addr = inp_ptr;
    assign wgt_rd_addr = wgt_ptr;
    assign out_tile    = tile;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        inp_rd_en = 1'b0;
        acc_clr   = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_nx = zero_cfg ? S_FIN : S_LOAD;
                end
            end
            S_LOAD: begin
                inp_rd_en = 1'b1;
                acc_clr   = (beat == '0);
                if (last_beat) begin
                    state_nx = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (drain_cnt == DW'(ARRAY_SIZE)) begin
                    state_nx = S_OUT;
                end
            end
            S_OUT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nx = last_tile ? S_FIN : S_LOAD;
                end
            end
            S_FIN: begin
                // An empty job lingers one extra FIN cycle before pulsing done.
                if (!skip) begin
                    done     = 1'b1;
                    state_nx = S_IDLE;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            k_len_q     <= '0;
            num_tiles_q <= '0;
            beat        <= '0;
            tile        <= '0;
            inp_ptr     <= '0;
            wgt_ptr     <= '0;
            wgt_base_q  <= '0;
            drain_cnt   <= '0;
            skip        <= 1'b0;
            stage_vld   <= '0;
        end else begin
            // One-cycle buffer read latency, then one stage per PE.
            stage_vld[0] <= inp_rd_en;
            for (int unsigned j = 1; j < ARRAY_SIZE; j++) begin
                stage_vld[j] <= stage_vld[j-1];
            end

            case (state)
                S_IDLE: begin
                    if (start) begin
                        k_len_q     <= k_len;
                        num_tiles_q <= num_tiles;
                        wgt_base_q  <= wgt_base;
                        inp_ptr     <= inp_base;
                        wgt_ptr     <= wgt_base;
                        tile        <= '0;
                        beat        <= '0;
                        skip        <= zero_cfg;
                    end
                end
                S_LOAD: begin
                    // Input pointer runs on across tiles: base + tile*k_len + beat.
                    inp_ptr   <= inp_ptr + ADDR_WIDTH'(1);
                    wgt_ptr   <= wgt_ptr + ADDR_WIDTH'(1);
                    beat      <= beat + CNT_WIDTH'(1);
                    drain_cnt <= '0;
                end
                S_DRAIN: begin
                    drain_cnt <= drain_cnt + DW'(1);
                end
                S_OUT: begin
                    if (out_ready && !last_tile) begin
                        tile    <= tile + CNT_WIDTH'(1);
                        beat    <= '0;
                        wgt_ptr <= wgt_base_q;
                    end
                end
                S_FIN: begin
                    skip <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_pe_chain_ctrl.sv
// Testbench for pe_chain_ctrl: directed jobs; expected read beats and tile
// handshakes are queued by the stimulus and consumed by a negedge monitor.
module tb_pe_chain_ctrl;

    localparam int AS = 4;
    localparam int AW = 8;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [CW-1:0] k_len;
    logic [CW-1:0] num_tiles;
    logic [AW-1:0] inp_base;
    logic [AW-1:0] wgt_base;
    logic          inp_rd_en;
    logic [AW-1:0] inp_rd_addr;
    logic          wgt_rd_en;
    logic [AW-1:0] wgt_rd_addr;
    logic          acc_clr;
    logic [AS-1:0] stage_vld;
    logic          out_valid;
    logic          out_ready;
    logic [CW-1:0] out_tile;
    logic          busy;
    logic          done;

    pe_chain_ctrl #(
        .ARRAY_SIZE(AS),
        .ADDR_WIDTH(AW),
        .CNT_WIDTH (CW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .k_len      (k_len),
        .num_tiles  (num_tiles),
        .inp_base   (inp_base),
        .wgt_base   (wgt_base),
        .inp_rd_en  (inp_rd_en),
        .inp_rd_addr(inp_rd_addr),
        .wgt_rd_en  (wgt_rd_en),
        .wgt_rd_addr(wgt_rd_addr),
        .acc_clr    (acc_clr),
        .stage_vld  (stage_vld),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_tile   (out_tile),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [AW-1:0] inp;
        logic [AW-1:0] wgt;
        logic          clr;
    } rd_t;

    rd_t           rd_q[$];
    logic [CW-1:0] tile_q[$];
    int            n_checks = 0;
    int            n_fail   = 0;
    int            done_cnt = 0;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endfunction

    function automatic void push_rd(input logic [AW-1:0] i, input logic [AW-1:0] w, input logic c);
        rd_t e;
        e.inp = i;
        e.wgt = w;
        e.clr = c;
        rd_q.push_back(e);
    endfunction

    // Monitor: consumes expected read beats and tile handshakes.
    always @(negedge clk) begin
        rd_t           e;
        logic [CW-1:0] et;
        if (!rst) begin
            if (inp_rd_en) begin
                if (rd_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected read: got addr 0x%0h, expected no read", inp_rd_addr);
                end else begin
                    e = rd_q.pop_front();
                    check("inp_rd_addr", inp_rd_addr, e.inp);
                    check("wgt_rd_addr", wgt_rd_addr, e.wgt);
                    check("acc_clr", acc_clr, e.clr);
                    check("wgt_rd_en", wgt_rd_en, 1);
                end
            end else begin
                check("acc_clr/wgt_rd_en without read", {acc_clr, wgt_rd_en}, 0);
            end
            if (out_valid && out_ready) begin
                if (tile_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected handshake: got tile %0d, expected none", out_tile);
                end else begin
                    et = tile_q.pop_front();
                    check("out_tile", out_tile, et);
                end
            end
            if (done) done_cnt++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_job(input logic [CW-1:0] k, input logic [CW-1:0] n,
                             input logic [AW-1:0] ib, input logic [AW-1:0] wb);
        k_len     = k;
        num_tiles = n;
        inp_base  = ib;
        wgt_base  = wb;
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string name);
        int seen;
        seen = 0;
        for (int i = 0; i < budget && seen == 0; i++) begin
            @(negedge clk);
            if (done) seen = 1;
        end
        check(name, seen, 1);
        tick();
    endtask

    // Start in cycle 0 and record per-cycle output bits for cycles 0..ncyc-1.
    task automatic run_trace(input logic [CW-1:0] k, input logic [CW-1:0] n,
                             input logic [AW-1:0] ib, input logic [AW-1:0] wb, input int ncyc,
                             output logic [15:0] m_rd, output logic [15:0] m_clr,
                             output logic [15:0] m_s3, output logic [15:0] m_ov,
                             output logic [15:0] m_dn, output logic [15:0] m_busy);
        m_rd = '0; m_clr = '0; m_s3 = '0; m_ov = '0; m_dn = '0; m_busy = '0;
        k_len = k; num_tiles = n; inp_base = ib; wgt_base = wb;
        start = 1'b1;
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            m_rd[c]   = inp_rd_en;
            m_clr[c]  = acc_clr;
            m_s3[c]   = stage_vld[AS-1];
            m_ov[c]   = out_valid;
            m_dn[c]   = done;
            m_busy[c] = busy;
            tick();
            start = 1'b0;
        end
    endtask

    logic [15:0] m_rd, m_clr, m_s3, m_ov, m_dn, m_busy;
    int          d0;
    int          seen;

    initial begin
        rst = 1'b1; start = 1'b0; out_ready = 1'b0;
        k_len = '0; num_tiles = '0; inp_base = '0; wgt_base = '0;
        tick();
        tick();
        @(negedge clk);
        check("reset outputs", {inp_rd_en, inp_rd_addr, wgt_rd_en, wgt_rd_addr, acc_clr, stage_vld,
                                out_valid, out_tile, busy, done}, 0);
        tick();
        rst = 1'b0;
        tick();

        // 1: single tile, k_len=3, exact cycle timing
        out_ready = 1'b1;
        push_rd(8'h10, 8'h40, 1'b1);
        push_rd(8'h11, 8'h41, 1'b0);
        push_rd(8'h12, 8'h42, 1'b0);
        tile_q.push_back(8'd0);
        d0 = done_cnt;
        run_trace(8'd3, 8'd1, 8'h10, 8'h40, 12, m_rd, m_clr, m_s3, m_ov, m_dn, m_busy);
        check("t1 rd_en cycles", m_rd, 16'h000E);
        check("t1 acc_clr cycles", m_clr, 16'h0002);
        check("t1 stage_vld[3] cycles", m_s3, 16'h00E0);
        check("t1 out_valid cycles", m_ov, 16'h0200);
        check("t1 done cycles", m_dn, 16'h0400);
        check("t1 busy cycles", m_busy, 16'h07FE);
        check("t1 done count", done_cnt - d0, 1);
        check("t1 queues drained", rd_q.size() + tile_q.size(), 0);

        // 2: three tiles, running input pointer, reused weights
        push_rd(8'h20, 8'h40, 1'b1); push_rd(8'h21, 8'h41, 1'b0);
        push_rd(8'h22, 8'h40, 1'b1); push_rd(8'h23, 8'h41, 1'b0);
        push_rd(8'h24, 8'h40, 1'b1); push_rd(8'h25, 8'h41, 1'b0);
        tile_q.push_back(8'd0); tile_q.push_back(8'd1); tile_q.push_back(8'd2);
        d0 = done_cnt;
        start_job(8'd2, 8'd3, 8'h20, 8'h40);
        wait_done(100, "t2 done seen");
        repeat (3) tick();
        check("t2 done count", done_cnt - d0, 1);
        check("t2 queues drained", rd_q.size() + tile_q.size(), 0);
        check("t2 busy after", busy, 0);

        // 3: backpressure in OUT
        out_ready = 1'b0;
        push_rd(8'h30, 8'h40, 1'b1);
        push_rd(8'h31, 8'h40, 1'b1);
        tile_q.push_back(8'd0); tile_q.push_back(8'd1);
        d0 = done_cnt;
        start_job(8'd1, 8'd2, 8'h30, 8'h40);
        seen = 0;
        for (int i = 0; i < 50 && seen == 0; i++) begin
            @(negedge clk);
            if (out_valid) seen = 1;
        end
        check("t3 out_valid seen", seen, 1);
        for (int i = 0; i < 5; i++) begin
            check("t3 stall out_valid", out_valid, 1);
            check("t3 stall out_tile", out_tile, 0);
            check("t3 stall no read", inp_rd_en, 0);
            tick();
            if (i == 4) out_ready = 1'b1;
            @(negedge clk);
        end
        check("t3 valid at handshake", out_valid, 1);
        @(negedge clk);
        check("t3 after handshake {rd_en,out_valid}", {inp_rd_en, out_valid}, 2'b10);
        wait_done(50, "t3 done seen");
        repeat (2) tick();
        check("t3 done count", done_cnt - d0, 1);
        check("t3 queues drained", rd_q.size() + tile_q.size(), 0);

        // 4: empty jobs
        d0 = done_cnt;
        run_trace(8'd0, 8'd5, 8'h00, 8'h00, 6, m_rd, m_clr, m_s3, m_ov, m_dn, m_busy);
        check("t4a rd_en", m_rd, 0);
        check("t4a out_valid", m_ov, 0);
        check("t4a done cycle", m_dn, 16'h0004);
        check("t4a busy cycles", m_busy, 16'h0006);
        run_trace(8'd3, 8'd0, 8'h00, 8'h00, 6, m_rd, m_clr, m_s3, m_ov, m_dn, m_busy);
        check("t4b rd_en", m_rd, 0);
        check("t4b out_valid", m_ov, 0);
        check("t4b done cycle", m_dn, 16'h0004);
        check("t4b busy cycles", m_busy, 16'h0006);
        check("t4 done count", done_cnt - d0, 2);

        // 5: start and config changes while busy are ignored
        push_rd(8'h50, 8'h60, 1'b1); push_rd(8'h51, 8'h61, 1'b0);
        push_rd(8'h52, 8'h60, 1'b1); push_rd(8'h53, 8'h61, 1'b0);
        tile_q.push_back(8'd0); tile_q.push_back(8'd1);
        d0 = done_cnt;
        start_job(8'd2, 8'd2, 8'h50, 8'h60);
        start = 1'b1; k_len = 8'd7; num_tiles = 8'd9; inp_base = 8'h00; wgt_base = 8'h00;
        tick();
        start = 1'b0;
        wait_done(100, "t5 done seen");
        repeat (20) tick();
        check("t5 busy after", busy, 0);
        check("t5 done count", done_cnt - d0, 1);
        check("t5 queues drained", rd_q.size() + tile_q.size(), 0);

        // 6: reset mid-LOAD, then wrapping job
        push_rd(8'h70, 8'h40, 1'b1);
        d0 = done_cnt;
        start_job(8'd3, 8'd1, 8'h70, 8'h40);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("t6 outputs after reset", {inp_rd_en, inp_rd_addr, wgt_rd_en, wgt_rd_addr, acc_clr, stage_vld,
                                         out_valid, out_tile, busy, done}, 0);
        check("t6 pre-reset read consumed", rd_q.size(), 0);
        tick();
        push_rd(8'hFE, 8'h40, 1'b1); push_rd(8'hFF, 8'h41, 1'b0);
        push_rd(8'h00, 8'h42, 1'b0); push_rd(8'h01, 8'h43, 1'b0);
        tile_q.push_back(8'd0);
        start_job(8'd4, 8'd1, 8'hFE, 8'h40);
        wait_done(100, "t6 done seen");
        repeat (3) tick();
        check("t6 done count", done_cnt - d0, 1);
        check("t6 queues drained", rd_q.size() + tile_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pe_chain_ctrl.md
Name: pe_chain_ctrl

Overview:
- Sequences one chain of ARRAY_SIZE signed MAC PEs, where each PE computes acc_out <= inp*wgt + acc_in and partial sums ripple down the chain.
- On start, it issues input and weight buffer reads for num_tiles tiles of k_len beats each, and tracks live data through the chain with a valid shift register.
- After each tile it drains the pipeline, then hands the tile result downstream with a valid/ready handshake.
- It sits between the operand SRAM buffers, the PE chain, and the result writeback logic.

Parameters:
- ARRAY_SIZE, 4, number of chained PEs (pipeline depth of the chain).
- ADDR_WIDTH, 8, operand buffer address width.
- CNT_WIDTH, 8, width of the k_len, num_tiles and tile index counters.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin job; sampled only in IDLE.
- k_len  in  CNT_WIDTH  beats per tile; latched at start.
- num_tiles  in  CNT_WIDTH  tiles per job; latched at start.
- inp_base  in  ADDR_WIDTH  input buffer base address; latched at start.
- wgt_base  in  ADDR_WIDTH  weight buffer base address; latched at start.
- inp_rd_en  out  1  input buffer read strobe.
- inp_rd_addr  out  ADDR_WIDTH  input read address.
- wgt_rd_en  out  1  weight buffer read strobe; always equal to inp_rd_en.
- wgt_rd_addr  out  ADDR_WIDTH  weight read address.
- acc_clr  out  1  forces the first PE's acc_in to zero; high on the first read beat of each tile.
- stage_vld  out  ARRAY_SIZE  bit j high means PE j holds live data.
- out_valid  out  1  tile result ready at the end of the chain.
- out_ready  in  1  downstream accepts the result.
- out_tile  out  CNT_WIDTH  index of the tile being presented.
- busy  out  1  high whenever state != IDLE.
- done  out  1  one-cycle pulse when the job completes.

Behaviour:
- Reset: state=IDLE; every output 0, including stage_vld, addresses, out_tile and done. Latched config and counters are cleared.
- Reset mid-operation: same effect at the next edge. Outstanding pipeline contents are abandoned and no out_valid or done is produced.
- FSM states: IDLE, LOAD, DRAIN, OUT, FIN.
- IDLE:
  - start=1 with k_len!=0 and num_tiles!=0: latch config, tile=0, beat=0, go to LOAD.
  - start=1 with k_len=0 or num_tiles=0: go to FIN. No reads and no out_valid occur.
- LOAD (exactly k_len cycles):
  - inp_rd_en=wgt_rd_en=1.
  - inp_rd_addr = inp_base + tile*k_len + beat. Computed with a running pointer, no multiplier.
  - wgt_rd_addr = wgt_base + beat. Weights are reused across tiles.
  - All addresses wrap modulo 2^ADDR_WIDTH.
  - acc_clr=1 only when beat=0.
  - After the beat k_len-1 cycle, go to DRAIN.
- Chain tracking:
  - Buffer read latency is 1 cycle.
  - stage_vld[0] = inp_rd_en delayed 1 cycle; stage_vld[j] = stage_vld[j-1] delayed 1 cycle.
  - stage_vld shifts in every state and only clears on reset.
- DRAIN: lasts exactly ARRAY_SIZE+1 cycles, then go to OUT.
- OUT:
  - out_valid=1 and out_tile=tile, both held stable until out_ready=1.
  - Handshake = out_valid & out_ready.
  - On handshake with tile<num_tiles-1: tile++, beat=0, go to LOAD. out_valid is low in the following cycle.
  - On handshake with tile=num_tiles-1: go to FIN.
  - out_ready while not in OUT is ignored.
- FIN: done=1 for exactly one cycle, busy=1, then go to IDLE.
- start while busy is ignored; it is neither queued nor latched.
- Config inputs changing after start have no effect.
- Per-tile latency: k_len + (ARRAY_SIZE+1) + stall cycles, counted from the first LOAD cycle to the OUT handshake.

Test Plan:
1. ARRAY_SIZE=4, inp_base=0x10, wgt_base=0x40, k_len=3, num_tiles=1, start in cycle 0, out_ready=1.
   - rd_en high cycles 1-3; inp addresses 0x10,0x11,0x12; wgt addresses 0x40,0x41,0x42.
   - acc_clr high in cycle 1 only; stage_vld[3] high cycles 5-7.
   - out_valid high in cycle 9 with out_tile=0; done in cycle 10; busy high cycles 1-10.
2. k_len=2, num_tiles=3, inp_base=0x20.
   - Input address sequences are 0x20,0x21 / 0x22,0x23 / 0x24,0x25; weights repeat 0x40,0x41 for every tile.
   - out_tile presents 0,1,2 in order; exactly one done pulse.
3. out_ready held low for 5 cycles in OUT.
   - out_valid and out_tile stay stable; no new reads are issued.
   - Handshake occurs on the first out_ready=1 cycle.
4. k_len=0 (and separately num_tiles=0).
   - No rd_en and no out_valid; done is high in cycle 2 after start in cycle 0.
5. start pulsed while in LOAD, and config inputs changed mid-job.
   - Job proceeds with the original config; no second job starts.
6. rst asserted in the second LOAD cycle, then inp_base=0xFE, k_len=4.
   - All outputs are 0 the cycle after reset.
   - The new job reads addresses 0xFE,0xFF,0x00,0x01 (wrap-around).
